mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-master round-robin arbiter in front of the single-port Memory.
//  Master 0 is the Core data/instruction port; master 1 is a secondary requester (DMA/boot loader).
//  Serializes accesses with a request/ack handshake and returns read data to the winning master.
//  Sits between the bus_interconnect memory side and Memory.
// PARAMETERS
//  ADDR_WIDTH      32   address width of masters and memory port
//  DATA_WIDTH      32   data width of masters and memory port
//  TIMEOUT_CYCLES  16   max ACCESS cycles before abort (only with MEM_ARB_TIMEOUT_EN); 1..255
// PORTS
//  clk            in   1           system clock, all logic on rising edge
//  rst            in   1           synchronous reset, active-high
//  m0_rd_en_i     in   1           master 0 read request (level, held until m0_ack_o)
//  m0_wr_en_i     in   1           master 0 write request (level, held until m0_ack_o)
//  m0_addr_i      in   ADDR_WIDTH  master 0 address
//  m0_data_i      in   DATA_WIDTH  master 0 write data
//  m0_data_o      out  DATA_WIDTH  master 0 read data, valid while m0_ack_o=1
//  m0_ack_o       out  1           master 0 transaction done, 1-cycle pulse
//  m0_err_o       out  1           master 0 timeout abort, coincident with m0_ack_o
//  m1_*           (same set as m0_*, for master 1)
//  mem_rd_en_o    out  1           memory read enable
//  mem_wr_en_o    out  1           memory write enable
//  mem_addr_o     out  ADDR_WIDTH  memory address
//  mem_data_o     out  DATA_WIDTH  memory write data
//  mem_data_i     in   DATA_WIDTH  memory read data
//  mem_ack_i      in   1           memory completion
//  grant_o        out  1           index of the master owning the memory (0/1)
//  busy_o         out  1           1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (master 0 preferred), all outputs 0, latched regs 0.
//   Reset mid-transaction drops it; mem enables are low from the first reset edge; no ack is issued.
//  Request: req_x = mx_rd_en_i | mx_wr_en_i; rd and wr both high -> write wins, op treated as write.
//  FSM:
//   IDLE: sampled only here.
//    Neither request -> stay in IDLE.
//    One request -> grant that master.
//    Both requests -> grant master rr_ptr.
//    On a grant: latch addr, wdata, op and grant_o, then go to ACCESS.
//   ACCESS: drive mem_*_o from the latched regs; the enable matching op stays high every cycle.
//    mem_ack_i=1 -> capture mem_data_i (reads; writes return 0), drop enables, go to RESP.
//    rr_ptr <= ~grant on the same edge (the last-served master loses priority).
//   RESP: exactly one cycle.
//    Winning mx_ack_o=1 with mx_data_o=captured data; the other master's ack stays 0.
//    Then go to IDLE.
//  Masters drop their request on the edge where they see ack; the IDLE cycle after RESP samples fresh requests.
//  Latency: request in IDLE cycle t -> mem enable at t+1.
//   Memory acks at cycle t+k -> master ack at t+k+1. Minimum 3 cycles per transaction.
//  Master inputs are ignored outside IDLE; changing them mid-transaction has no effect.
//  mx_data_o is 0 whenever mx_ack_o=0.
//  No back-to-back grants without an IDLE cycle; sustained contention alternates 0,1,0,1.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
//   At count == TIMEOUT_CYCLES with no mem_ack_i: drop enables, go to RESP.
//   That RESP cycle has mx_ack_o=1, mx_err_o=1, mx_data_o=0; rr_ptr still rotates.
//   mem_ack_i in the same cycle as the limit -> normal completion, err=0.
//  Not defined: no counter; ACCESS waits indefinitely; m0_err_o and m1_err_o tied to 0.
// TESTING
//  1 Reset held 3 cycles with m0 read pending -> all outputs 0, busy_o=0; after release the read proceeds.
//  2 m0 read 0x0000_0010, mem acks 1 cycle after enable with 0xCAFE_F00D
//     -> mem_rd_en_o high 2 cycles, m0_ack_o one pulse with m0_data_o=0xCAFE_F00D, 4 cycles total.
//  3 m0 and m1 write simultaneously, 0x100<-0x11 and 0x104<-0x22, from reset
//     -> m0 is served first, then m1; memory holds both values; grant_o sequence 0,1.
//  4 Both masters issue 4 continuous reads each -> grants alternate 0,1,0,1,...; neither starves.
//  5 m1 asserts rd and wr together to 0x20 with data 0x5 -> write issued, mem_rd_en_o never high.
//  6 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ack_i held 0
//     -> m0_ack_o=m0_err_o=1 after 4 ACCESS cycles, m0_data_o=0; the next m1 request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter serializing accesses onto a single-port memory.
// Optional ACCESS timeout abort is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_rd_en_i,
    input  logic                  m0_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_rd_en_i,
    input  logic                  m1_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,
    output logic                  grant_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  grant_q, grant_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  req0, req1, sel;
    logic                  timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // cnt_q counts ACCESS cycles already completed; the limit includes the current one.
    assign timeout_hit = (state_q == ACCESS) && ((cnt_q + 8'd1) == TO_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    assign req0 = m0_rd_en_i | m0_wr_en_i;
    assign req1 = m1_rd_en_i | m1_wr_en_i;
    assign sel  = (req0 && req1) ? rr_q : req1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = 8'd0;
`endif
                if (req0 || req1) begin
                    grant_d = sel;
                    addr_d  = sel ? m1_addr_i : m0_addr_i;
                    wdata_d = sel ? m1_data_i : m0_data_i;
                    // A simultaneous rd+wr is treated as a write.
                    op_wr_d = sel ? m1_wr_en_i : m0_wr_en_i;
                    rdata_d = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (mem_ack_i) begin
                    rdata_d = op_wr_q ? '0 : mem_data_i;
                    rr_d    = ~grant_q;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    rr_d    = ~grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            grant_q <= 1'b0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign mem_rd_en_o = (state_q == ACCESS) && !op_wr_q;
    assign mem_wr_en_o = (state_q == ACCESS) &&  op_wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = wdata_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);

    assign m0_ack_o  = (state_q == RESP) && !grant_q;
    assign m1_ack_o  = (state_q == RESP) &&  grant_q;
    assign m0_data_o = m0_ack_o ? rdata_q : '0;
    assign m1_data_o = m1_ack_o ? rdata_q : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    assign m0_err_o = m0_ack_o && err_q;
    assign m1_err_o = m1_ack_o && err_q;
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory of configurable ack latency.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_rd_en_i = 1'b0, m0_wr_en_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m0_data_i = '0;
    logic [31:0] m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_rd_en_i = 1'b0, m1_wr_en_i = 1'b0;
    logic [31:0] m1_addr_i = '0, m1_data_i = '0;
    logic [31:0] m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic        mem_rd_en_o, mem_wr_en_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [31:0] mem_data_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        grant_o, busy_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [31:0] mem [0:255];
    int  mem_lat  = 1;
    bit  hold_off = 1'b0;
    int  en_cnt   = 0;

    int          rem0, rem1, rd_cycles;
    bit          rd_seen, exp_err;
    int          glog[$];
    logic [31:0] dlog[$];

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_rd_en_i(m0_rd_en_i), .m0_wr_en_i(m0_wr_en_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_rd_en_i(m1_rd_en_i), .m1_wr_en_i(m1_wr_en_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Memory acks after mem_lat enabled cycles; the DUT samples the ack on the next rising edge.
    always @(negedge clk) begin
        if ((mem_rd_en_o || mem_wr_en_o) && !hold_off) begin
            if (en_cnt == mem_lat) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem_rd_en_o ? mem[mem_addr_o[9:2]] : 32'h0;
                if (mem_wr_en_o) mem[mem_addr_o[9:2]] = mem_data_o;
                en_cnt = 0;
            end else begin
                mem_ack_i = 1'b0;
                en_cnt++;
            end
        end else begin
            mem_ack_i  = 1'b0;
            mem_data_i = 32'h0;
            en_cnt     = 0;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the bus until rem0/rem1 acks have been seen, logging grant order and data.
    task automatic serve(input int budget);
        glog.delete();
        dlog.delete();
        for (int c = 0; c < budget && (rem0 > 0 || rem1 > 0); c++) begin
            tick();
            if (mem_rd_en_o) begin
                rd_cycles++;
                rd_seen = 1'b1;
            end
            if (m0_ack_o) begin
                glog.push_back(0);
                dlog.push_back(m0_data_o);
                chk_val("m0_grant", {31'h0, grant_o}, 32'h0);
                chk_val("m0_err", {31'h0, m0_err_o}, {31'h0, exp_err});
                rem0--;
                if (rem0 == 0) begin
                    m0_rd_en_i = 1'b0;
                    m0_wr_en_i = 1'b0;
                end
            end else begin
                chk_val("m0_data_zero", m0_data_o, 32'h0);
            end
            if (m1_ack_o) begin
                glog.push_back(1);
                dlog.push_back(m1_data_o);
                chk_val("m1_grant", {31'h0, grant_o}, 32'h1);
                chk_val("m1_err", {31'h0, m1_err_o}, {31'h0, exp_err});
                rem1--;
                if (rem1 == 0) begin
                    m1_rd_en_i = 1'b0;
                    m1_wr_en_i = 1'b0;
                end
            end else begin
                chk_val("m1_data_zero", m1_data_o, 32'h0);
            end
        end
        chk_val("serve_budget", 32'(rem0 + rem1), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[2]  = 32'h1234_5678;
        mem[4]  = 32'hCAFE_F00D;
        mem[12] = 32'h0000_00A0;
        mem[13] = 32'h0000_00B1;
        exp_err = 1'b0;

        // 1: reset held with m0 read pending
        m0_rd_en_i = 1'b1;
        m0_addr_i  = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_val("rst_busy", {31'h0, busy_o}, 32'h0);
            chk_val("rst_mem_en", {30'h0, mem_rd_en_o, mem_wr_en_o}, 32'h0);
            chk_val("rst_acks", {28'h0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'h0);
            chk_val("rst_grant", {31'h0, grant_o}, 32'h0);
            chk_val("rst_mem_addr", mem_addr_o, 32'h0);
        end
        rst = 1'b0;
        rem0 = 1; rem1 = 0;
        serve(20);
        chk_val("t1_data", dlog.size() > 0 ? dlog[0] : 32'hDEAD_DEAD, 32'h1234_5678);

        // 2: single read, memory acks one cycle after enable
        tick();
        chk_val("t2_idle", {31'h0, busy_o}, 32'h0);
        mem_lat    = 1;
        m0_rd_en_i = 1'b1;
        m0_addr_i  = 32'h10;
        tick();
        chk_val("t2_rd_en_c1", {31'h0, mem_rd_en_o}, 32'h1);
        chk_val("t2_addr_c1", mem_addr_o, 32'h10);
        m0_addr_i = 32'h99;
        tick();
        chk_val("t2_rd_en_c2", {31'h0, mem_rd_en_o}, 32'h1);
        chk_val("t2_addr_held", mem_addr_o, 32'h10);
        chk_val("t2_no_ack_yet", {31'h0, m0_ack_o}, 32'h0);
        tick();
        chk_val("t2_ack", {31'h0, m0_ack_o}, 32'h1);
        chk_val("t2_data", m0_data_o, 32'hCAFE_F00D);
        chk_val("t2_rd_en_off", {31'h0, mem_rd_en_o}, 32'h0);
        chk_val("t2_m1_ack", {31'h0, m1_ack_o}, 32'h0);
        m0_rd_en_i = 1'b0;
        tick();
        chk_val("t2_back_idle", {30'h0, busy_o, m0_ack_o}, 32'h0);

        // 3: simultaneous writes straight after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_lat = 0;
        m0_wr_en_i = 1'b1; m0_addr_i = 32'h100; m0_data_i = 32'h11;
        m1_wr_en_i = 1'b1; m1_addr_i = 32'h104; m1_data_i = 32'h22;
        rem0 = 1; rem1 = 1;
        serve(40);
        chk_val("t3_first", 32'(glog.size() > 0 ? glog[0] : 9), 32'h0);
        chk_val("t3_second", 32'(glog.size() > 1 ? glog[1] : 9), 32'h1);
        chk_val("t3_mem100", mem[64], 32'h11);
        chk_val("t3_mem104", mem[65], 32'h22);

        // 4: sustained read contention alternates
        mem_lat = 2;
        m0_wr_en_i = 1'b0; m1_wr_en_i = 1'b0;
        m0_rd_en_i = 1'b1; m0_addr_i = 32'h30;
        m1_rd_en_i = 1'b1; m1_addr_i = 32'h34;
        rem0 = 4; rem1 = 4;
        serve(200);
        chk_val("t4_count", 32'(glog.size()), 32'd8);
        for (int i = 0; i < glog.size(); i++) begin
            chk_val($sformatf("t4_grant%0d", i), 32'(glog[i]), 32'(i % 2));
            chk_val($sformatf("t4_data%0d", i), dlog[i], (i % 2 == 0) ? 32'hA0 : 32'hB1);
        end

        // 5: rd+wr together from m1 is a write
        mem_lat = 1;
        rd_seen = 1'b0;
        m1_rd_en_i = 1'b1; m1_wr_en_i = 1'b1; m1_addr_i = 32'h20; m1_data_i = 32'h5;
        rem0 = 0; rem1 = 1;
        serve(30);
        chk_val("t5_rd_never", {31'h0, rd_seen}, 32'h0);
        chk_val("t5_mem20", mem[8], 32'h5);
        chk_val("t5_wr_data_o", dlog.size() > 0 ? dlog[0] : 32'hDEAD_DEAD, 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: memory never acks -> abort after 4 ACCESS cycles
        hold_off = 1'b1;
        exp_err  = 1'b1;
        rd_cycles = 0;
        m0_rd_en_i = 1'b1; m0_addr_i = 32'h10;
        rem0 = 1; rem1 = 0;
        serve(50);
        chk_val("t6_access_cycles", 32'(rd_cycles), 32'd4);
        chk_val("t6_err_data", dlog.size() > 0 ? dlog[0] : 32'hDEAD_DEAD, 32'h0);
        hold_off = 1'b0;
        exp_err  = 1'b0;
        m1_rd_en_i = 1'b1; m1_addr_i = 32'h10;
        rem0 = 0; rem1 = 1;
        serve(50);
        chk_val("t6_m1_data", dlog.size() > 0 ? dlog[0] : 32'hDEAD_DEAD, 32'hCAFE_F00D);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
